// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Parametrised raster timing generator with pixel-clock divider and
//            PIPE_DELAY-tick alignment pipeline on hsync/vsync/video_on.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CLK_DIV    = 1,
    parameter int PIPE_DELAY = 2,
    parameter int CW         = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic          pix_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          vblank,
    output logic          line_start,
    output logic          frame_start,
    output logic          vis_end
);

    localparam int c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_h_last   = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_last   = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_vis    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] c_v_vis    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] c_h_vis_l  = CW'(H_VISIBLE - 1);
    localparam logic [CW-1:0] c_v_vis_l  = CW'(V_VISIBLE - 1);
    localparam logic [CW-1:0] c_hs_start = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] c_hs_end   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] c_vs_start = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] c_vs_end   = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [3:0]    c_div_last = 4'(CLK_DIV - 1);
    localparam logic          c_hpol     = (H_SYNC_POL != 0);
    localparam logic          c_vpol     = (V_SYNC_POL != 0);

    logic [3:0]    r_div_cnt;
    logic [CW-1:0] r_h_count;
    logic [CW-1:0] r_v_count;
    logic          w_pix_tick;
    logic [2:0]    w_raw;   // {hs, vs, va} in asserted-high sense
    logic [2:0]    w_del;

    // Gated by reset_n so the strobe reads 0 throughout reset even when CLK_DIV=1.
    assign w_pix_tick = reset_n && enable && (r_div_cnt == c_div_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (!enable) begin
            r_div_cnt <= '0;
            r_h_count <= '0;
            r_v_count <= '0;
        end else if (w_pix_tick) begin
            r_div_cnt <= '0;
            if (r_h_count == c_h_last) begin
                r_h_count <= '0;
                r_v_count <= (r_v_count == c_v_last) ? '0 : r_v_count + c_one;
            end else begin
                r_h_count <= r_h_count + c_one;
            end
        end else begin
            r_div_cnt <= r_div_cnt + 4'd1;
        end
    end

    assign w_raw[2] = (r_h_count >= c_hs_start) && (r_h_count < c_hs_end);
    assign w_raw[1] = (r_v_count >= c_vs_start) && (r_v_count < c_vs_end);
    assign w_raw[0] = (r_h_count < c_h_vis) && (r_v_count < c_v_vis);

    generate
        if (PIPE_DELAY > 0) begin : g_pipe
            logic [PIPE_DELAY-1:0][2:0] r_pipe;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipe <= '0;
                end else if (!enable) begin
                    r_pipe <= '0;
                end else if (w_pix_tick) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_del = r_pipe[PIPE_DELAY-1];
        end else begin : g_nopipe
            // Counters sit at (0,0) while held, which is inside the active area.
            assign w_del = {w_raw[2:1], w_raw[0] & reset_n & enable};
        end
    endgenerate

    assign pix_tick    = w_pix_tick;
    assign x           = r_h_count;
    assign y           = r_v_count;
    assign hsync       = w_del[2] ? c_hpol : ~c_hpol;
    assign vsync       = w_del[1] ? c_vpol : ~c_vpol;
    assign video_on    = w_del[0];
    assign vblank      = (r_v_count >= c_v_vis);
    assign line_start  = w_pix_tick && (r_h_count == '0);
    assign frame_start = w_pix_tick && (r_h_count == '0) && (r_v_count == '0);
    assign vis_end     = w_pix_tick && (r_h_count == c_h_vis_l) && (r_v_count == c_v_vis_l);

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Scoreboard bench for vga_timing_gen on a reduced raster, two
//            configurations (divided/pipelined/active-low, direct/active-high).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    localparam int HV = 10, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic enable = 1'b0;

    logic          a_pix_tick, a_hsync, a_vsync, a_video_on, a_vblank;
    logic          a_line_start, a_frame_start, a_vis_end;
    logic [CW-1:0] a_x, a_y;
    logic          b_pix_tick, b_hsync, b_vsync, b_video_on, b_vblank;
    logic          b_line_start, b_frame_start, b_vis_end;
    logic [CW-1:0] b_x, b_y;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(2), .PIPE_DELAY(2), .CW(CW)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_tick(a_pix_tick),
        .x(a_x), .y(a_y), .hsync(a_hsync), .vsync(a_vsync), .video_on(a_video_on),
        .vblank(a_vblank), .line_start(a_line_start), .frame_start(a_frame_start),
        .vis_end(a_vis_end)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(1), .PIPE_DELAY(0), .CW(CW)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_tick(b_pix_tick),
        .x(b_x), .y(b_y), .hsync(b_hsync), .vsync(b_vsync), .video_on(b_video_on),
        .vblank(b_vblank), .line_start(b_line_start), .frame_start(b_frame_start),
        .vis_end(b_vis_end)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: counters per instance, plus a delay queue of raw flags for dut_a.
    int         m_div [2];
    int         m_h   [2];
    int         m_v   [2];
    logic [2:0] q_a[$];

    function automatic logic [2:0] raw_flags(input int h, input int v);
        return {(h >= HV + HF) && (h < HV + HF + HS),
                (v >= VV + VF) && (v < VV + VF + VS),
                (h < HV) && (v < VV)};
    endfunction

    function automatic logic m_tick(input int i);
        return reset_n && enable && (m_div[i] == ((i == 0) ? 1 : 0));
    endfunction

    function automatic logic [31:0] exp_a();
        logic       t;
        logic [2:0] d;
        t = m_tick(0);
        d = q_a[0];
        return {8'd0, t, 8'(m_h[0]), 8'(m_v[0]), ~d[2], ~d[1], d[0], (m_v[0] >= VV),
                t && (m_h[0] == 0), t && (m_h[0] == 0) && (m_v[0] == 0),
                t && (m_h[0] == HV - 1) && (m_v[0] == VV - 1)};
    endfunction

    function automatic logic [31:0] exp_b();
        logic       t;
        logic [2:0] r;
        t = m_tick(1);
        r = raw_flags(m_h[1], m_v[1]);
        return {8'd0, t, 8'(m_h[1]), 8'(m_v[1]), r[2], r[1], r[0] && reset_n && enable,
                (m_v[1] >= VV), t && (m_h[1] == 0), t && (m_h[1] == 0) && (m_v[1] == 0),
                t && (m_h[1] == HV - 1) && (m_v[1] == VV - 1)};
    endfunction

    function automatic logic [31:0] got_a();
        return {8'd0, a_pix_tick, a_x, a_y, a_hsync, a_vsync, a_video_on, a_vblank,
                a_line_start, a_frame_start, a_vis_end};
    endfunction

    function automatic logic [31:0] got_b();
        return {8'd0, b_pix_tick, b_x, b_y, b_hsync, b_vsync, b_video_on, b_vblank,
                b_line_start, b_frame_start, b_vis_end};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_div[i] = 0;
            m_h[i]   = 0;
            m_v[i]   = 0;
        end
        q_a.delete();
        q_a.push_back(3'b000);
        q_a.push_back(3'b000);
    endtask

    // Apply the upcoming clock edge to the model.
    task automatic model_advance();
        if (!reset_n || !enable) begin
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_tick(i)) begin
                    if (i == 0) begin
                        q_a.push_back(raw_flags(m_h[0], m_v[0]));
                        void'(q_a.pop_front());
                    end
                    m_div[i] = 0;
                    if (m_h[i] == HT - 1) begin
                        m_h[i] = 0;
                        m_v[i] = (m_v[i] == VT - 1) ? 0 : m_v[i] + 1;
                    end else begin
                        m_h[i] = m_h[i] + 1;
                    end
                end else begin
                    m_div[i] = m_div[i] + 1;
                end
            end
        end
    endtask

    logic counting = 1'b0;
    int   cnt_fs_a = 0, cnt_ve_a = 0, cnt_va_a = 0, cnt_hlow_a = 0, cnt_fs_b = 0;

    task automatic run_cycles(input int n, input logic en, input logic rn);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            enable  = en;
            reset_n = rn;
            #1;
            check_val("cycle_a", got_a(), exp_a());
            check_val("cycle_b", got_b(), exp_b());
            if (counting) begin
                cnt_fs_a   += int'(a_frame_start);
                cnt_ve_a   += int'(a_vis_end);
                cnt_va_a   += int'(a_pix_tick && a_video_on);
                cnt_hlow_a += int'(!a_hsync);
                cnt_fs_b   += int'(b_frame_start);
            end
            model_advance();
        end
    endtask

    initial begin
        logic found;
        // Reset asserted with no clock edge yet.
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check_val("reset_a", got_a(), exp_a());
        check_val("reset_b", got_b(), exp_b());
        run_cycles(3, 1'b0, 1'b0);
        run_cycles(3, 1'b1, 1'b0);

        // Free run across frame wraps.
        run_cycles(400, 1'b1, 1'b1);

        // One full dut_a frame: 170 ticks at CLK_DIV=2.
        counting = 1'b1;
        run_cycles(2 * HT * VT, 1'b1, 1'b1);
        counting = 1'b0;
        check_val("frame_starts_a", 32'(cnt_fs_a), 32'd1);
        check_val("vis_ends_a", 32'(cnt_ve_a), 32'd1);
        check_val("video_ticks_a", 32'(cnt_va_a), 32'(HV * VV));
        check_val("hsync_low_clks_a", 32'(cnt_hlow_a), 32'(2 * HS * VT));
        check_val("frame_starts_b", 32'(cnt_fs_b), 32'd2);

        // Drop enable on a tick mid-line, hold, then re-enable.
        found = 1'b0;
        for (int k = 0; k < 4 * HT * VT && !found; k++) begin
            if (m_h[0] == 5 && m_v[0] == 3 && m_div[0] == 1) found = 1'b1;
            else run_cycles(1, 1'b1, 1'b1);
        end
        check_val("find_drop_point", 32'(found), 32'd1);
        run_cycles(5, 1'b0, 1'b1);
        run_cycles(400, 1'b1, 1'b1);

        // Asynchronous reset between clock edges.
        run_cycles(123, 1'b1, 1'b1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("async_reset_a", got_a(), exp_a());
        check_val("async_reset_b", got_b(), exp_b());
        run_cycles(2, 1'b1, 1'b0);
        run_cycles(360, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator; next generation of the fixed 640x480 VGA controller. Timing, sync polarity, pixel-clock division and an output alignment pipeline are all set by parameters. Sits between the system clock and the BEV pixel pipeline. Raw x/y drive frame-buffer address generation. Delayed sync/video_on line up with pixel data arriving PIPE_DELAY pixel ticks later.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, hsync asserted level (0 = active-low)
V_SYNC_POL, 0, vsync asserted level (0 = active-low)
CLK_DIV, 1, clk cycles per pixel tick (1..16)
PIPE_DELAY, 2, pixel ticks of delay on hsync/vsync/video_on (0..8)
CW, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run when high; low clears and holds the generator
pix_tick  out  1  one-clk pixel strobe; all counters advance on it
x  out  CW  current h_count (undelayed)
y  out  CW  current v_count (undelayed)
hsync  out  1  horizontal sync, delayed PIPE_DELAY ticks
vsync  out  1  vertical sync, delayed PIPE_DELAY ticks
video_on  out  1  active-area flag, delayed PIPE_DELAY ticks
vblank  out  1  v_count >= V_VISIBLE (undelayed)
line_start  out  1  pulse: pix_tick and h_count==0
frame_start  out  1  pulse: pix_tick and h_count==0 and v_count==0
vis_end  out  1  pulse: pix_tick, h_count==H_VISIBLE-1, v_count==V_VISIBLE-1 (buffer-swap point)

Behaviour:
- H_TOTAL = sum of the H parameters; V_TOTAL = sum of the V parameters.
- Reset (async on reset_n low): div_cnt=0, h_count=0, v_count=0, all delay stages inactive.
- Output values during reset: pix_tick=0; x=0, y=0; hsync=~H_SYNC_POL; vsync=~V_SYNC_POL; video_on=0; vblank=0; all pulses 0.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable=1. pix_tick = enable && div_cnt==CLK_DIV-1 (combinational). CLK_DIV=1 gives pix_tick=enable.
- On each pix_tick, h_count increments. At H_TOTAL-1, h_count wraps to 0 and v_count increments. At v_count V_TOTAL-1 with h_count H_TOTAL-1, both wrap to 0.
- Raw sync: hs_raw asserted for H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC.
- vs_raw is the same on v_count with the V parameters.
- va_raw = h_count<H_VISIBLE && v_count<V_VISIBLE.
- Delay pipeline: PIPE_DELAY-stage shift of {hs_raw, vs_raw, va_raw}, shifting only on pix_tick. Outputs come from the last stage, mapped to polarity: asserted = *_SYNC_POL.
- PIPE_DELAY=0: outputs are combinational from the counters.
- After reset or re-enable, the first PIPE_DELAY ticks output the inactive levels.
- enable low (synchronous, next clk edge): div_cnt, counters and pipeline clear to reset state and hold.
- On re-enable, the first pix_tick occurs CLK_DIV clks after enable rises, at (0,0), with frame_start=1.
- enable falling on the same clk as a pix_tick: the tick is suppressed (pix_tick gated combinationally); the clear takes priority.
- Pulses are exactly one clk wide, never more than one per tick. frame_start implies line_start on the same cycle.
- All arithmetic is unsigned CW-bit. No counter ever exceeds TOTAL-1.

Test Plan:
- Defaults, reset_n released, enable=1 -> x=0..799, y=0..524, wraps. 420000 ticks per frame. frame_start every 420000 clks. vis_end at (639,479).
- Defaults, PIPE_DELAY=2 -> hsync low on exactly 96 consecutive clks, first low when x=658. vsync low across lines 490..491 shifted by 2 ticks. video_on high 640 ticks per active line, 307200 per frame.
- CLK_DIV=4 -> pix_tick every 4th clk. Counters hold between ticks. Frame = 1680000 clks. Pulses remain one clk wide.
- H_SYNC_POL=1, V_SYNC_POL=1, PIPE_DELAY=0 -> hsync high exactly when 656<=x<752, same cycle, with no lag.
- Drop enable mid-line at (300,100), hold 5 clks, raise -> x=y=0 next clk, outputs inactive. First tick after re-enable has frame_start=1. First PIPE_DELAY ticks have video_on=0.
- Assert reset_n=0 asynchronously mid-frame -> outputs take reset values immediately, without a clk edge. Release -> sequence restarts from (0,0).
